// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32 M-extension unit for the EX stage.
// One multiply (shift-add) or restoring-divide iteration per cycle, a single
// sign-fixup cycle, and a registered one-cycle completion pulse. Division by
// zero and signed overflow complete without iterating.
//
// Ports:
//   clkIn      - clock, rising edge active
//   resetIn    - asynchronous active-high reset
//   validIn    - M-extension op present in ID/EX this cycle
//   funct3In   - 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   Data1In    - rs1 operand
//   Data2In    - rs2 operand
//   rdIn       - destination register
//   flushIn    - abort any in-flight op, no result
//   stallOut   - combinational hold for ID/EX and earlier stages
//   doneOut    - one-cycle pulse, resultOut/rdOut valid
//   resultOut  - registered result, held between pulses
//   rdOut      - registered destination register, held between pulses
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clkIn,
    input  logic            resetIn,
    input  logic            validIn,
    input  logic [2:0]      funct3In,
    input  logic [XLEN-1:0] Data1In,
    input  logic [XLEN-1:0] Data2In,
    input  logic [4:0]      rdIn,
    input  logic            flushIn,
    output logic            stallOut,
    output logic            doneOut,
    output logic [XLEN-1:0] resultOut,
    output logic [4:0]      rdOut
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned CW = 5;
    localparam int unsigned RW = 5;
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] opnd;   // multiplicand (mul) or divisor (div) magnitude
    logic [AW-1:0]   acc;    // {hi, lo} product, or {remainder, quotient}
    logic            neg_q;  // product/quotient sign differs
    logic            neg_r;  // dividend negative

    // Incoming operand decode
    logic            in_div;
    logic            in_s1;
    logic            in_s2;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            div_ovf;
    logic [AW-1:0]   special_acc;

    always_comb begin
        in_div      = funct3In[2];
        in_s1       = (funct3In == 3'd1) || (funct3In == 3'd2) ||
                      (funct3In == 3'd4) || (funct3In == 3'd6);
        in_s2       = (funct3In == 3'd1) || (funct3In == 3'd4) || (funct3In == 3'd6);
        neg1        = in_s1 && Data1In[XLEN-1];
        neg2        = in_s2 && Data2In[XLEN-1];
        mag1        = neg1 ? -Data1In : Data1In;
        mag2        = neg2 ? -Data2In : Data2In;
        div_zero    = in_div && (Data2In == '0);
        div_ovf     = in_div && in_s2 && (Data1In == MIN_INT) && (Data2In == ALL_ONES);
        // Divide-by-zero wins: {rem = dividend, quo = all ones}; overflow: {0, MIN_INT}
        special_acc = div_zero ? {Data1In, ALL_ONES} : {{XLEN{1'b0}}, MIN_INT};
    end

    // One iteration of each algorithm
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [AW-1:0]   div_next;

    always_comb begin
        // Right-shifting product: multiplier bits leave from acc[0]
        mul_sum   = {1'b0, acc[AW-1:XLEN]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[AW-1:1]};
        // Restoring divide: shift next dividend bit into the partial remainder
        div_shift = {acc[AW-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_next  = div_ge ? {div_shift[XLEN-1:0] - opnd, acc[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Sign correction and result selection
    logic [AW-1:0]   fixed;
    logic            sel_hi;
    logic [XLEN-1:0] result_sel;

    always_comb begin
        if (f3[2]) begin
            fixed = {neg_r ? -acc[AW-1:XLEN] : acc[AW-1:XLEN],
                     neg_q ? -acc[XLEN-1:0]  : acc[XLEN-1:0]};
        end else begin
            fixed = neg_q ? -acc : acc;
        end
        // MULH* and REM* take the upper half
        sel_hi     = f3[2] ? f3[1] : (f3[1:0] != 2'd0);
        result_sel = sel_hi ? acc[AW-1:XLEN] : acc[XLEN-1:0];
    end

    // Stall is gated by reset so the pipeline sees no hold while reset is asserted
    assign stallOut = !resetIn &&
                      (((state == IDLE) && validIn && !flushIn) ||
                       (state == CALC) || (state == FIXUP));

    // Control FSM with registered outputs
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state     <= IDLE;
            cnt       <= '0;
            f3        <= '0;
            rd        <= '0;
            opnd      <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            doneOut   <= 1'b0;
            resultOut <= '0;
            rdOut     <= '0;
        end else begin
            doneOut <= 1'b0;
            if (flushIn) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (validIn) begin
                            f3    <= funct3In;
                            rd    <= rdIn;
                            neg_q <= neg1 ^ neg2;
                            neg_r <= neg1;
                            cnt   <= '0;
                            if (div_zero || div_ovf) begin
                                acc   <= special_acc;
                                state <= DONE;
                            end else begin
                                opnd  <= in_div ? mag2 : mag1;
                                acc   <= {{XLEN{1'b0}}, in_div ? mag1 : mag2};
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc <= f3[2] ? div_next : mul_next;
                        if (cnt == '1) begin
                            state <= FIXUP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    FIXUP: begin
                        acc   <= fixed;
                        state <= DONE;
                    end
                    DONE: begin
                        doneOut   <= 1'b1;
                        resultOut <= result_sel;
                        rdOut     <= rd;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: directed spec vectors, randomized ops against an
// arithmetic reference model, flush, mid-op reset and DONE-state behaviour.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [2:0]  funct3;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  rd;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks   = 0;
    int failures = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clkIn    (clk),
        .resetIn  (rst),
        .validIn  (valid),
        .funct3In (funct3),
        .Data1In  (data1),
        .Data2In  (data2),
        .rdIn     (rd),
        .flushIn  (flush),
        .stallOut (stall),
        .doneOut  (done),
        .resultOut(result),
        .rdOut    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        longint p;
        int     sa;
        int     sb;
        logic   ovf;
        sa  = a;
        sb  = b;
        la  = (f == 3'd1 || f == 3'd2) ? longint'(sa) : longint'({32'h0, a});
        lb  = (f == 3'd1) ? longint'(sb) : longint'({32'h0, b});
        p   = la * lb;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, then wait (bounded) for doneOut; lat = -1 on timeout
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int stalls);
        @(negedge clk);
        valid  = 1'b1;
        funct3 = f;
        data1  = a;
        data2  = b;
        rd     = r;
        #1;
        stalls = stall ? 1 : 0;
        res    = 'x;
        rdo    = 'x;
        lat    = -1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k;
                res = result;
                rdo = rd_out;
                break;
            end
            if (stall) stalls++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (rd_out !== 5'h0)  begin failures++; $display("FAIL reset_rd: got %h want 0", rd_out); end
        valid = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_idle_done: got %b want 0", done); end
    endtask

    task automatic test_directed();
        logic [2:0]  fs  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
        logic [31:0] as  [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                  32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000};
        logic [31:0] bs  [11] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7,
                                  32'd7, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] exp [11] = '{32'd42, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                  32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          stalls;
        int          exp_lat;
        for (int i = 0; i < 11; i++) begin
            exp_lat = (i >= 8) ? 1 : 34;
            do_op(fs[i], as[i], bs[i], 5'(i + 5), res, rdo, lat, stalls);
            checks++; if (lat !== exp_lat) begin failures++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            checks++; if (res !== exp[i])  begin failures++; $display("FAIL dir%0d_result: got %h want %h", i, res, exp[i]); end
            checks++; if (rdo !== 5'(i + 5)) begin failures++; $display("FAIL dir%0d_rd: got %0d want %0d", i, rdo, i + 5); end
            checks++; if (stalls !== exp_lat) begin failures++; $display("FAIL dir%0d_stall_cycles: got %0d want %0d", i, stalls, exp_lat); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || result !== exp[i]) begin
                failures++; $display("FAIL dir%0d_hold: done %b result %h want 0/%h", i, done, result, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          stalls;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            r = 5'($urandom);
            do_op(f, a, b, r, res, rdo, lat, stalls);
            checks++; if (res !== model(f, a, b)) begin
                failures++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, model(f, a, b));
            end
            checks++; if (lat !== model_latency(f, a, b) || rdo !== r) begin
                failures++; $display("FAIL rnd%0d_lat_rd: got lat %0d rd %0d want %0d/%0d", i, lat, rdo, model_latency(f, a, b), r);
            end
        end
    endtask

    task automatic test_flush();
        int          pulses;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          stalls;
        @(negedge clk);
        valid = 1'b1; funct3 = 3'd5; data1 = 32'hFFFF_FFFF; data2 = 32'd3; rd = 5'd9;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b want 0", stall); end
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL flush_no_done: got %0d pulses want 0", pulses); end
        do_op(3'd5, 32'd9, 32'd3, 5'd12, res, rdo, lat, stalls);
        checks++; if (res !== 32'd3 || lat !== 34) begin
            failures++; $display("FAIL flush_next_op: got %h lat %0d want 3 lat 34", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        int          pulses;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          stalls;
        do_op(3'd0, 32'd7, 32'd6, 5'd5, res, rdo, lat, stalls);
        @(negedge clk);
        valid = 1'b1; funct3 = 3'd4; data1 = 32'd1000; data2 = 32'd7; rd = 5'd3;
        @(posedge clk);
        @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (result !== 32'h0 || rd_out !== 5'h0) begin
            failures++; $display("FAIL rst_mid_outputs: result %h rd %0d want 0/0", result, rd_out);
        end
        checks++; if (stall !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ctrl: stall %b done %b want 0/0", stall, done);
        end
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done || stall) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_done_state();
        int pulses;
        // validIn presented in DONE starts nothing
        @(negedge clk);
        valid = 1'b1; funct3 = 3'd5; data1 = 32'd9; data2 = 32'd3; rd = 5'd7;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (33) @(negedge clk);
        checks++; if (done !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL done_state_ctrl: done %b stall %b want 0/0", done, stall);
        end
        valid = 1'b1; funct3 = 3'd0; data1 = 32'd2; data2 = 32'd2; rd = 5'd1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL done_state_valid_stall: got %b want 0", stall); end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (done !== 1'b1 || result !== 32'd3 || rd_out !== 5'd7) begin
            failures++; $display("FAIL done_state_pulse: done %b result %h rd %0d want 1/3/7", done, result, rd_out);
        end
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done || stall) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL done_state_no_requeue: got %0d active cycles want 0", pulses); end
        // flush in DONE suppresses the pulse and keeps the old result
        @(negedge clk);
        valid = 1'b1; funct3 = 3'd0; data1 = 32'd11; data2 = 32'd11; rd = 5'd2;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (33) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0 || result !== 32'd3) begin
            failures++; $display("FAIL done_state_flush: pulses %0d result %h want 0/3", pulses, result);
        end
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        funct3 = 3'd0;
        data1  = 32'h0;
        data2  = 32'h0;
        rd     = 5'h0;
        flush  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_done_state();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clkIn  input  1  single clock; all state changes on rising edge.
REQ-003 resetIn  input  1  asynchronous, active-high reset.
REQ-004 validIn  input  1  EX-stage M-extension op present in the ID/EX outputs this cycle.
REQ-005 funct3In  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 Data1In  input  32  rs1 operand from the ID/EX register.
REQ-007 Data2In  input  32  rs2 operand from the ID/EX register.
REQ-008 rdIn  input  5  destination register from the ID/EX register.
REQ-009 flushIn  input  1  abort the in-flight op; no result produced.
REQ-010 stallOut  output  1  hold the ID/EX and earlier pipeline registers.
REQ-011 doneOut  output  1  one-cycle pulse; resultOut/rdOut valid.
REQ-012 resultOut  output  32  operation result.
REQ-013 rdOut  output  5  destination register of the completed op.

Function
REQ-014 FSM states IDLE, CALC, FIXUP, DONE; the state SHALL be IDLE after reset.
REQ-015 In IDLE, validIn=1 with flushIn=0 at an edge SHALL latch funct3, operands and rd, and take operand magnitudes per signedness.
- MULH/DIV/REM: both operands signed.
- MULHSU: rs1 signed only.
- Others: unsigned.
REQ-016 A divide with Data2In=0, or signed divide of 0x80000000 by 0xFFFFFFFF, SHALL go IDLE->DONE directly with the special result.
REQ-017 All other ops SHALL go IDLE->CALC, clear a 5-bit counter, and perform one iteration per cycle in CALC.
- Multiply: shift-add into a 64-bit product.
- Divide: restoring; 32-bit quotient and remainder.
REQ-018 CALC SHALL exit to FIXUP after exactly 32 iterations (counter 31 -> FIXUP); the counter SHALL not wrap into a 33rd iteration.
REQ-019 FIXUP SHALL apply sign correction in one cycle and then go to DONE.
- Product: negated if operand signs differ.
- Quotient: negated if signs differ.
- Remainder: takes the dividend's sign.
REQ-020 Result selection SHALL be as follows.
- MUL: product[31:0].
- MULH/MULHSU/MULHU: product[63:32].
- DIV/DIVU: quotient.
- REM/REMU: remainder.
REQ-021 Divide-by-zero results SHALL be: quotient 0xFFFFFFFF (DIV and DIVU), remainder = Data1In.
REQ-022 Signed overflow results SHALL be: quotient 0x80000000, remainder 0.
REQ-023 DONE SHALL assert doneOut for exactly one cycle, drive resultOut/rdOut registered, and return to IDLE at the next edge.
REQ-024 Normal latency: validIn sampled at edge T0 -> doneOut high in the cycle following edge T0+34.
REQ-025 Special-case latency: validIn sampled at edge T0 -> doneOut high in the cycle following edge T0+1.
REQ-026 stallOut SHALL be combinational: high when (IDLE and validIn and not flushIn) or state is CALC or FIXUP; low in DONE so the held instruction retires.
REQ-027 validIn SHALL be ignored in CALC, FIXUP and DONE; no second op is queued.
REQ-028 flushIn=1 at an edge in any state SHALL force IDLE with no doneOut pulse; flushIn takes priority over validIn.
REQ-029 resultOut and rdOut SHALL hold their last values when doneOut=0.

Reset
REQ-030 Asserting resetIn SHALL immediately clear state to IDLE and clear the counter, with stallOut=0, doneOut=0, resultOut=0, rdOut=0.
REQ-031 Reset mid-operation SHALL discard the op; after release, only a new validIn starts work.

Verification
REQ-032 MUL: 7 x 6, rd=5 -> stallOut high 34 cycles, then doneOut pulse with resultOut=42, rdOut=5.
REQ-033 Sign handling:
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 Divide:
- DIV -7 / 2 -> 0xFFFFFFFD.
- REM -7 / 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14.
- REMU 100 / 7 -> 2.
REQ-035 Special cases, each with doneOut one cycle after acceptance:
- DIV 5 / 0 -> 0xFFFFFFFF.
- REM 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-036 flushIn at cycle 10 of CALC -> IDLE next cycle, no doneOut, stallOut low; a following DIVU 9 / 3 completes with 3.
REQ-037 resetIn pulsed mid-CALC -> all outputs 0 immediately, no doneOut after release; validIn held during DONE starts no new op.
